vga_line_fetch_arb: RTL and testbench

- Schedules a single-port synchronous frame memory shared by two users:
  - the VGA display path, which needs one packed scan line copied into its line buffer ahead of each active line;
  - the host / sort engine, which performs single-word reads and writes.
- The display fetch always has priority. The host is served in the gaps between fetches.
- Sits between the VGA timing/pattern logic and the frame memory, in the VGA_CTRL_CLK domain.

---
 rtl/vga_line_fetch_arb.sv | 126 ++++++++++++
 tb/tb_vga_line_fetch_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch_arb.sv
// Frame-memory arbiter: display line fetch has absolute priority, and host
// single-word accesses fill the gaps. One memory port, read latency of one
// cycle, everything in the pixel clock domain.
module vga_line_fetch_arb #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WPL    = 80,
    parameter int V_ACT  = 1024,
    parameter int LB_AW  = 7
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iLINE_REQ,
    input  logic [10:0]       iLINE,
    output logic              oFETCH_BUSY,
    output logic              oLB_WE,
    output logic [LB_AW-1:0]  oLB_ADDR,
    output logic [DATA_W-1:0] oLB_DATA,
    input  logic              iHOST_REQ,
    input  logic              iHOST_WE,
    input  logic [ADDR_W-1:0] iHOST_ADDR,
    input  logic [DATA_W-1:0] iHOST_WDATA,
    output logic              oHOST_ACK,
    output logic [DATA_W-1:0] oHOST_RDATA,
    output logic              oHOST_RVALID,
    output logic [ADDR_W-1:0] oMEM_ADDR,
    output logic              oMEM_WE,
    output logic [DATA_W-1:0] oMEM_WDATA,
    input  logic [DATA_W-1:0] iMEM_RDATA,
    output logic              oOVERRUN
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOST} state_t;

    state_t             state, state_nxt;
    logic               pending;
    logic [ADDR_W-1:0]  req_base;    // base of the queued line
    logic [ADDR_W-1:0]  fetch_addr;  // running address of the line being fetched
    logic [LB_AW-1:0]   k;
    logic [LB_AW-1:0]   lb_addr;
    logic               lb_we;
    logic               rvalid;
    logic               overrun;
    logic               req_ok;
    logic [ADDR_W-1:0]  line_base;

    assign req_ok    = iLINE_REQ && (32'(iLINE) < 32'(V_ACT));
    assign line_base = ADDR_W'(32'(iLINE) * 32'(WPL));

    // Next-state and memory-port mux. A line request arriving while idle
    // holds the host off for one cycle so the fetch still wins the port.
    always_comb begin
        state_nxt  = state;
        oMEM_ADDR  = '0;
        oMEM_WE    = 1'b0;
        oMEM_WDATA = '0;
        oHOST_ACK  = 1'b0;
        case (state)
            IDLE: begin
                if (pending)
                    state_nxt = FETCH;
                else if (iHOST_REQ && !req_ok)
                    state_nxt = HOST;
            end
            FETCH: begin
                oMEM_ADDR = fetch_addr;
                if (k == LB_AW'(WPL - 1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = iHOST_REQ ? HOST : IDLE;
            end
            HOST: begin
                oMEM_ADDR  = iHOST_ADDR;
                oMEM_WE    = iHOST_WE;
                oMEM_WDATA = iHOST_WDATA;
                oHOST_ACK  = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, request latch, fetch counters and the one-cycle-delayed strobes.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state      <= IDLE;
            pending    <= 1'b0;
            req_base   <= '0;
            fetch_addr <= '0;
            k          <= '0;
            lb_we      <= 1'b0;
            lb_addr    <= '0;
            rvalid     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state   <= state_nxt;
            lb_we   <= (state == FETCH);
            lb_addr <= k;
            rvalid  <= (state == HOST) && !iHOST_WE;
            overrun <= req_ok && pending;
            if (state == IDLE && pending) begin
                pending    <= 1'b0;
                k          <= '0;
                fetch_addr <= req_base;
            end else if (state == FETCH) begin
                k          <= k + 1'b1;
                fetch_addr <= fetch_addr + 1'b1;
            end
            // A second request while one is queued is dropped (overrun above).
            if (req_ok && !pending) begin
                pending  <= 1'b1;
                req_base <= line_base;
            end
        end
    end

    assign oFETCH_BUSY  = pending || (state == FETCH) || (state == DRAIN);
    assign oLB_WE       = lb_we;
    assign oLB_ADDR     = lb_addr;
    assign oLB_DATA     = lb_we ? iMEM_RDATA : '0;
    assign oHOST_RVALID = rvalid;
    assign oHOST_RDATA  = rvalid ? iMEM_RDATA : '0;
    assign oOVERRUN     = overrun;

endmodule

// File: tb/tb_vga_line_fetch_arb.sv
// Bench for vga_line_fetch_arb: random frame memory, line fetches and host
// accesses checked against a reference copy of memory and timing rules.
module tb_vga_line_fetch_arb;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int WPL    = 80;
    localparam int V_ACT  = 1024;
    localparam int LB_AW  = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              iLINE_REQ = 1'b0;
    logic [10:0]       iLINE = '0;
    logic              oFETCH_BUSY, oLB_WE, oHOST_ACK, oHOST_RVALID, oMEM_WE, oOVERRUN;
    logic [LB_AW-1:0]  oLB_ADDR;
    logic [DATA_W-1:0] oLB_DATA, oHOST_RDATA, oMEM_WDATA, mem_rdata;
    logic              iHOST_REQ = 1'b0, iHOST_WE = 1'b0;
    logic [ADDR_W-1:0] iHOST_ADDR = '0, oMEM_ADDR;
    logic [DATA_W-1:0] iHOST_WDATA = '0;

    vga_line_fetch_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WPL(WPL), .V_ACT(V_ACT), .LB_AW(LB_AW)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iLINE_REQ(iLINE_REQ), .iLINE(iLINE),
        .oFETCH_BUSY(oFETCH_BUSY), .oLB_WE(oLB_WE), .oLB_ADDR(oLB_ADDR), .oLB_DATA(oLB_DATA),
        .iHOST_REQ(iHOST_REQ), .iHOST_WE(iHOST_WE), .iHOST_ADDR(iHOST_ADDR), .iHOST_WDATA(iHOST_WDATA),
        .oHOST_ACK(oHOST_ACK), .oHOST_RDATA(oHOST_RDATA), .oHOST_RVALID(oHOST_RVALID),
        .oMEM_ADDR(oMEM_ADDR), .oMEM_WE(oMEM_WE), .oMEM_WDATA(oMEM_WDATA),
        .iMEM_RDATA(mem_rdata), .oOVERRUN(oOVERRUN)
    );

    always #5 clk = ~clk;

    logic [76:0] all_out;
    assign all_out = {oFETCH_BUSY, oLB_WE, oLB_ADDR, oLB_DATA, oHOST_ACK, oHOST_RDATA,
                      oHOST_RVALID, oMEM_ADDR, oMEM_WE, oMEM_WDATA, oOVERRUN};

    // Frame memory (sync read, one-cycle latency) and its reference copy.
    logic [DATA_W-1:0] mem     [0:65535];
    logic [DATA_W-1:0] ref_mem [0:65535];
    bit loaded = 1'b0;

    // Memory model: loads the random image on the first edge, then serves the DUT.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= ref_mem[i];
            loaded <= 1'b1;
        end else begin
            mem_rdata <= mem[oMEM_ADDR];
            if (oMEM_WE) mem[oMEM_ADDR] <= oMEM_WDATA;
        end
    end

    int cyc = 0;
    // Edge counter used to time-stamp observations.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [LB_AW-1:0] addr; logic [DATA_W-1:0] data; } lb_t;
    lb_t lb_q[$];
    int  ovr_cnt, busy_cnt, busy_last, stray_we;
    int  nvec = 0, nerr = 0;

    // Passive monitor sampling on the falling edge.
    always @(negedge clk) begin
        if (oLB_WE) lb_q.push_back('{cyc, oLB_ADDR, oLB_DATA});
        if (oOVERRUN) ovr_cnt++;
        if (oFETCH_BUSY) begin busy_cnt++; busy_last = cyc; end
        if (oMEM_WE && !oHOST_ACK) stray_we++;
    end

    task automatic step(); @(posedge clk); #1; endtask

    task automatic clear_logs();
        lb_q.delete(); ovr_cnt = 0; busy_cnt = 0; busy_last = -1; stray_we = 0;
    endtask

    task automatic pulse_line(input int line, output int r);
        iLINE_REQ = 1'b1; iLINE = 11'(line);
        step();
        r = cyc;
        iLINE_REQ = 1'b0;
    endtask

    task automatic host_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                               output int lat, output logic we_at_ack, output logic rv, output logic [15:0] rd);
        int t0;
        t0 = cyc; lat = -1; we_at_ack = 1'b0;
        iHOST_REQ = 1'b1; iHOST_WE = we; iHOST_ADDR = a; iHOST_WDATA = d;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (oHOST_ACK) begin lat = cyc - t0; we_at_ack = oMEM_WE; break; end
        end
        step();
        iHOST_REQ = 1'b0; iHOST_WE = 1'b0;
        @(negedge clk);
        rv = oHOST_RVALID; rd = oHOST_RDATA;
        step();
    endtask

    // Counts beats of one recorded line that break the expected order, data or contiguity.
    function automatic int lb_errors(input int first, input logic [15:0] base);
        int errs = 0;
        logic [15:0] a;
        if (lb_q.size() < first + WPL) return 999;
        for (int i = 0; i < WPL; i++) begin
            a = base + 16'(i);
            if (lb_q[first+i].addr != LB_AW'(i) || lb_q[first+i].data !== ref_mem[a]) errs++;
            if (i > 0 && lb_q[first+i].cyc != lb_q[first+i-1].cyc + 1) errs++;
        end
        return errs;
    endfunction

    function automatic logic [15:0] line_base(input int line);
        return 16'((line * WPL) % 65536);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        nvec++; if (all_out !== '0) begin nerr++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fetch_line3();
        int r, errs, first;
        clear_logs();
        pulse_line(3, r);
        repeat (100) step();
        errs = lb_errors(0, 16'd240);
        first = (lb_q.size() > 0) ? lb_q[0].cyc : -1;
        nvec++; if (lb_q.size() !== WPL) begin nerr++; $display("FAIL fetch3_beats: got %0d expected %0d", lb_q.size(), WPL); end
        nvec++; if (errs !== 0) begin nerr++; $display("FAIL fetch3_data: got %0d bad beats expected 0", errs); end
        nvec++; if (first !== r + 2) begin nerr++; $display("FAIL fetch3_first_we: got cycle %0d expected %0d", first, r + 2); end
        nvec++; if (busy_last !== r + WPL + 1) begin nerr++; $display("FAIL fetch3_busy_fall: got %0d expected %0d", busy_last, r + WPL + 1); end
        nvec++; if (ovr_cnt !== 0) begin nerr++; $display("FAIL fetch3_overrun: got %0d expected 0", ovr_cnt); end
    endtask

    task automatic test_priority();
        int r, lat, line, errs;
        logic wa, rv;
        logic [15:0] rd;
        clear_logs();
        line = $urandom_range(0, V_ACT - 1);
        fork
            pulse_line(line, r);
            host_access(1'b1, 16'h0005, 16'h1234, lat, wa, rv, rd);
        join
        repeat (5) step();
        errs = lb_errors(0, line_base(line));
        nvec++; if (errs !== 0) begin nerr++; $display("FAIL prio_fetch_data: line %0d got %0d bad beats expected 0", line, errs); end
        nvec++; if (lat !== WPL + 3) begin nerr++; $display("FAIL prio_ack_latency: got %0d expected %0d", lat, WPL + 3); end
        nvec++; if (rv !== 1'b0) begin nerr++; $display("FAIL prio_write_rvalid: got %0b expected 0", rv); end
        ref_mem[5] = 16'h1234;
        nvec++; if (mem[5] !== 16'h1234) begin nerr++; $display("FAIL prio_mem_write: got %h expected 1234", mem[5]); end
    endtask

    task automatic test_host_read();
        int lat;
        logic wa, rv;
        logic [15:0] rd;
        clear_logs();
        host_access(1'b0, 16'h0100, 16'h0000, lat, wa, rv, rd);
        nvec++; if (lat !== 1) begin nerr++; $display("FAIL hread_ack_latency: got %0d expected 1", lat); end
        nvec++; if (rv !== 1'b1 || rd !== ref_mem[16'h0100]) begin nerr++; $display("FAIL hread_data: got rv=%0b %h expected rv=1 %h", rv, rd, ref_mem[16'h0100]); end
        nvec++; if (wa !== 1'b0 || stray_we !== 0) begin nerr++; $display("FAIL hread_mem_we: got %0b/%0d expected 0/0", wa, stray_we); end
    endtask

    task automatic test_host_random();
        int lat;
        logic wa, rv, we;
        logic [15:0] a, d, rd, last_wa;
        last_wa = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            we = (i == 15) ? 1'b0 : 1'($urandom_range(0, 1));
            a  = (i == 15) ? last_wa : 16'($urandom);
            d  = 16'($urandom);
            host_access(we, a, d, lat, wa, rv, rd);
            nvec++; if (lat !== 1 || wa !== we) begin nerr++; $display("FAIL hrand_ack: op %0d got lat=%0d we=%0b expected 1/%0b", i, lat, wa, we); end
            if (we) begin
                ref_mem[a] = d; last_wa = a;
                nvec++; if (rv !== 1'b0) begin nerr++; $display("FAIL hrand_wr_rvalid: op %0d got %0b expected 0", i, rv); end
            end else begin
                nvec++; if (rv !== 1'b1 || rd !== ref_mem[a]) begin nerr++; $display("FAIL hrand_rd: op %0d addr %h got rv=%0b %h expected 1 %h", i, a, rv, rd, ref_mem[a]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int la, lb, lc, r, e0, e1, gap;
        la = $urandom_range(0, V_ACT - 1);
        lb = $urandom_range(0, V_ACT - 1);
        lc = $urandom_range(0, V_ACT - 1);
        clear_logs();
        pulse_line(la, r);
        repeat (10) step();
        pulse_line(lb, r);
        repeat (20) step();
        pulse_line(lc, r);
        repeat (200) step();
        e0 = lb_errors(0, line_base(la));
        e1 = lb_errors(WPL, line_base(lb));
        gap = (lb_q.size() > WPL) ? lb_q[WPL].cyc - lb_q[WPL-1].cyc : -1;
        nvec++; if (lb_q.size() !== 2 * WPL) begin nerr++; $display("FAIL b2b_beats: got %0d expected %0d", lb_q.size(), 2 * WPL); end
        nvec++; if (e0 !== 0 || e1 !== 0) begin nerr++; $display("FAIL b2b_data: got %0d/%0d bad beats expected 0/0", e0, e1); end
        nvec++; if (gap !== 3) begin nerr++; $display("FAIL b2b_gap: got %0d expected 3", gap); end
        nvec++; if (ovr_cnt !== 1) begin nerr++; $display("FAIL b2b_overrun: got %0d expected 1", ovr_cnt); end
    endtask

    task automatic test_invalid_line();
        int r;
        clear_logs();
        pulse_line(1024, r);
        pulse_line($urandom_range(1025, 2047), r);
        repeat (10) step();
        nvec++; if (busy_cnt !== 0) begin nerr++; $display("FAIL inval_busy: got %0d busy cycles expected 0", busy_cnt); end
        nvec++; if (ovr_cnt !== 0 || lb_q.size() !== 0) begin nerr++; $display("FAIL inval_activity: got ovr=%0d beats=%0d expected 0/0", ovr_cnt, lb_q.size()); end
    endtask

    task automatic test_reset_midfetch();
        int r, errs;
        clear_logs();
        pulse_line($urandom_range(0, V_ACT - 1), r);
        repeat (40) step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        nvec++; if (all_out !== '0) begin nerr++; $display("FAIL midfetch_reset_outputs: got %h expected 0", all_out); end
        step();
        rst_n = 1'b1;
        step();
        clear_logs();
        pulse_line(0, r);
        repeat (100) step();
        errs = lb_errors(0, 16'h0000);
        nvec++; if (lb_q.size() !== WPL || errs !== 0) begin nerr++; $display("FAIL post_reset_fetch: got %0d beats %0d bad expected %0d/0", lb_q.size(), errs, WPL); end
        // Reset landing on a host read cycle must suppress its rvalid.
        iHOST_REQ = 1'b1; iHOST_WE = 1'b0; iHOST_ADDR = 16'($urandom);
        step();
        rst_n = 1'b0; iHOST_REQ = 1'b0;
        step();
        @(negedge clk);
        nvec++; if (oHOST_RVALID !== 1'b0 || all_out !== '0) begin nerr++; $display("FAIL host_abort: got rvalid=%0b out=%h expected 0", oHOST_RVALID, all_out); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random_lines();
        int r, line, errs;
        for (int i = 0; i < 4; i++) begin
            line = (i == 0) ? V_ACT - 1 : $urandom_range(0, V_ACT - 1);
            clear_logs();
            pulse_line(line, r);
            repeat (90) step();
            errs = lb_errors(0, line_base(line));
            nvec++; if (lb_q.size() !== WPL || errs !== 0) begin nerr++; $display("FAIL rand_line: line %0d got %0d beats %0d bad expected %0d/0", line, lb_q.size(), errs, WPL); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'($urandom);
        clear_logs();
        test_reset();
        test_fetch_line3();
        test_priority();
        test_host_read();
        test_host_random();
        test_back_to_back();
        test_invalid_line();
        test_reset_midfetch();
        test_random_lines();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
